// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MCU IOBUS.
// Stores to BASE_ADDR queue a byte in a FIFO; STATUS is readable at BASE_ADDR+4.
module iobus_uart_tx #(
    parameter int          CLK_RATE   = 50,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h11000040
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        TX,
    output logic        BUSY
);
    localparam int DIV   = (CLK_RATE * 1000000) / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]    FIFO_FULL   = CW'(FIFO_DEPTH);
    localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_baud_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_tx_nxt;
    logic             w_busy_nxt;

    logic w_wr_data;
    logic w_wr_status;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_baud_done;
    logic w_unused_data;

    assign w_wr_data     = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
    assign w_wr_status   = IOBUS_WR && (IOBUS_ADDR == STATUS_ADDR);
    assign w_full        = (r_count == FIFO_FULL);
    assign w_empty       = (r_count == '0);
    // A full FIFO drops the byte even when a pop frees a slot this cycle.
    assign w_push        = w_wr_data && !w_full;
    assign w_pop         = (r_state == ST_IDLE) && !w_empty;
    assign w_baud_done   = (r_baud_cnt == BAUD_LAST);
    assign w_unused_data = ^IOBUS_OUT[31:8];

    // FIFO storage, written only on an accepted push
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= IOBUS_OUT[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_wr_data && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // FSM state register and bit-timing datapath
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Next-state logic: each non-IDLE state lasts DIV cycles
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + BAUD_ONE;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                if (w_pop) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_state_nxt = ST_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_state_nxt = ST_IDLE;
                    w_baud_nxt  = '0;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so TX and BUSY can be registered without lag
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_IDLE:  w_tx_nxt = 1'b1;
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            ST_STOP:  w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
        // A store landing on the stop-to-idle edge keeps BUSY up across the gap cycle.
        w_busy_nxt = (w_state_nxt != ST_IDLE) || !w_empty
                     || (w_push && (r_state != ST_IDLE));
    end

    // Registered serial line and busy flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TX   <= 1'b1;
            BUSY <= 1'b0;
        end else begin
            TX   <= w_tx_nxt;
            BUSY <= w_busy_nxt;
        end
    end

    // STATUS read mux
    always_comb begin
        RD_DATA = 32'h0000_0000;
        if (IOBUS_ADDR == STATUS_ADDR) begin
            RD_DATA = {16'h0000, 8'(r_count), 4'h0, r_overflow,
                       (r_state != ST_IDLE), w_empty, w_full};
        end else begin
            RD_DATA = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx: directed scenarios plus random stores,
// compared against a frame-timeline reference model and a TX line decoder.
module tb_iobus_uart_tx;
    localparam int          CLK_RATE = 1;
    localparam int          BAUD     = 100000;
    localparam int          DEPTH    = 4;
    localparam int          DIV      = (CLK_RATE * 1000000) / BAUD;
    localparam int          FRAME    = 10 * DIV;
    localparam logic [31:0] BASE     = 32'h11000040;
    localparam logic [31:0] STAT     = BASE + 32'd4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IOBUS_ADDR = 32'h0;
    logic [31:0] IOBUS_OUT = 32'h0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] RD_DATA;
    logic        TX;
    logic        BUSY;

    int checks = 0;
    int failures = 0;

    // reference model: FIFO contents and the frame currently on the line
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    bit         active = 1'b0;
    int         start = 0;
    int         e = 0;
    logic       ovf = 1'b0;

    // TX line decoder
    logic [7:0] rx_q[$];
    logic [7:0] rx_b = 8'h00;
    int         rx_t = -1;

    iobus_uart_tx #(
        .CLK_RATE(CLK_RATE), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA), .TX(TX), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_nonidle();
        return active && (e < start + FRAME);
    endfunction

    function automatic logic m_tx();
        int o;
        int b;
        if (m_nonidle()) begin
            o = e - start;
            b = o / DIV;
            if (b == 0) return 1'b0;
            else if (b <= 8) return cur[b-1];
            else return 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        return {16'h0000, 8'(q.size()), 4'h0, ovf, m_nonidle(),
                (q.size() == 0), (q.size() == DEPTH)};
    endfunction

    task automatic model_reset();
        q.delete();
        active = 1'b0;
        ovf = 1'b0;
        rx_t = -1;
        rx_q.delete();
    endtask

    // one clock: drive inputs, advance the model over the edge, check TX, decode the line
    task automatic cycle(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bit idle_before;
        int sz;
        IOBUS_WR = wr;
        IOBUS_ADDR = addr;
        IOBUS_OUT = data;
        @(posedge CLK);
        idle_before = !m_nonidle();
        e++;
        sz = q.size();
        if (idle_before && sz > 0) begin
            cur = q.pop_front();
            active = 1'b1;
            start = e;
        end
        if (wr && addr == BASE) begin
            if (sz == DEPTH) ovf = 1'b1;
            else q.push_back(data[7:0]);
        end else if (wr && addr == STAT) begin
            ovf = 1'b0;
        end
        #1;
        check("tx_line", {31'h0, TX}, {31'h0, m_tx()});
        if (rx_t < 0) begin
            if (TX == 1'b0) begin
                rx_t = 0;
                rx_b = 8'h00;
            end
        end else begin
            rx_t++;
            if ((rx_t % DIV) == DIV / 2 && rx_t / DIV >= 1 && rx_t / DIV <= 8)
                rx_b[rx_t/DIV-1] = TX;
            if (rx_t == 9 * DIV + DIV / 2) begin
                rx_q.push_back(rx_b);
                rx_t = -1;
            end
        end
        IOBUS_WR = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0);
    endtask

    task automatic read_status(input string tag);
        IOBUS_WR = 1'b0;
        IOBUS_ADDR = STAT;
        #1;
        check(tag, RD_DATA, m_status());
    endtask

    initial begin
        int r;
        int a;
        int n;
        logic [31:0] sent;
        // reset state
        repeat (3) @(posedge CLK);
        #1;
        IOBUS_ADDR = STAT;
        #1;
        check("reset_tx", {31'h0, TX}, 32'h1);
        check("reset_busy", {31'h0, BUSY}, 32'h0);
        check("reset_status", RD_DATA, 32'h0000_0002);
        RESET = 1'b0;
        idle(3);

        // single byte 0xA5
        cycle(1'b1, BASE, 32'hFFFF_FFA5);
        check("busy_at_write_edge", {31'h0, BUSY}, 32'h0);
        for (int i = 1; i <= 101; i++) begin
            cycle(1'b0, 32'h0, 32'h0);
            if (i == 1) check("busy_rise", {31'h0, BUSY}, 32'h1);
            if (i == 100) check("busy_last_stop", {31'h0, BUSY}, 32'h1);
            if (i == 101) check("busy_fall", {31'h0, BUSY}, 32'h0);
        end
        read_status("single_status_model");
        check("single_status", RD_DATA, 32'h0000_0002);
        check("single_rx", {24'h0, rx_q.pop_front()}, 32'h0000_00A5);

        // back-to-back 0x55, 0x0F
        cycle(1'b1, BASE, 32'h0000_0055);
        cycle(1'b1, BASE, 32'h0000_000F);
        read_status("b2b_status_model");
        check("b2b_count", {24'h0, RD_DATA[15:8]}, 32'h1);
        for (int i = 2; i <= 210; i++) begin
            cycle(1'b0, 32'h0, 32'h0);
            if (i == 100) check("b2b_stop", {31'h0, TX}, 32'h1);
            if (i == 101) check("b2b_gap", {31'h0, TX}, 32'h1);
            if (i == 102) check("b2b_start2", {31'h0, TX}, 32'h0);
        end
        check("b2b_rx_n", rx_q.size(), 32'd2);
        check("b2b_rx0", {24'h0, rx_q.pop_front()}, 32'h55);
        check("b2b_rx1", {24'h0, rx_q.pop_front()}, 32'h0F);

        // overflow: six stores, the sixth is dropped
        for (int i = 1; i <= 6; i++) cycle(1'b1, BASE, i);
        read_status("ovf_status_model");
        check("ovf_status", RD_DATA, 32'h0000_040D);
        cycle(1'b1, STAT, 32'hFFFF_FFFF);
        read_status("ovf_clear_model");
        check("ovf_clear_bit3", {31'h0, RD_DATA[3]}, 32'h0);
        idle(5 * (FRAME + 1) + 20);
        check("ovf_rx_n", rx_q.size(), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            sent = {24'h0, rx_q.pop_front()};
            check("ovf_rx_order", sent, i);
        end

        // address decode
        cycle(1'b1, BASE + 32'd8, 32'h0000_0077);
        cycle(1'b1, BASE - 32'd4, 32'h0000_0099);
        idle(5);
        read_status("decode_status_model");
        check("decode_status", RD_DATA, 32'h0000_0002);
        IOBUS_ADDR = BASE + 32'd8;
        #1;
        check("decode_rd_plus8", RD_DATA, 32'h0);
        IOBUS_ADDR = BASE;
        #1;
        check("decode_rd_base", RD_DATA, 32'h0);
        check("decode_rx_none", rx_q.size(), 32'd0);

        // asynchronous reset during data bit 3 of 0x00 with two bytes queued
        cycle(1'b1, BASE, 32'h0000_0000);
        cycle(1'b1, BASE, 32'h0000_0011);
        cycle(1'b1, BASE, 32'h0000_0022);
        n = 0;
        while (e < start + 4 * DIV + 5 && n < 200) begin
            cycle(1'b0, 32'h0, 32'h0);
            n++;
        end
        read_status("rst_pre_status");
        check("rst_pre_busy", {31'h0, BUSY}, 32'h1);
        check("rst_pre_tx", {31'h0, TX}, 32'h0);
        #1;
        RESET = 1'b1;
        #1;
        check("rst_async_tx", {31'h0, TX}, 32'h1);
        check("rst_async_busy", {31'h0, BUSY}, 32'h0);
        model_reset();
        @(posedge CLK);
        e++;
        #1;
        RESET = 1'b0;
        read_status("rst_post_model");
        check("rst_post_status", RD_DATA, 32'h0000_0002);
        idle(FRAME + 30);
        check("rst_no_frames", rx_q.size(), 32'd0);

        // random stores checked against the model
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 15);
            if (r <= 2) a = BASE;
            else if (r == 3) a = STAT;
            else if (r == 4) a = BASE + 32'd8;
            else a = 0;
            cycle((a != 0), a, $urandom);
            if ((i % 16) == 5) read_status("rand_status");
        end
        idle(DEPTH * (FRAME + 1) + FRAME + 10);
        read_status("rand_final_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
